spi_tx_arbiter: RTL and testbench
=================================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge), reset (synchronous, active-high).
REQ-002 The block SHALL have these parameters, one per line as name, default, meaning:
- FRAME_LEN, 8, bytes per granted frame (1..255).
- GAP_CYCLES, 2, idle cycles after each byte hand-off (>=2).
- TIMEOUT_CYCLES, 1023, watchdog limit (used only with the macro in REQ-019).
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- req0 / req1, in, 1, requester 0/1 wants to send a frame; held high for the whole frame.
- data0 / data1, in, 8, current byte from requester 0/1.
- ack0 / ack1, out, 1, one-cycle pulse: current byte consumed, requester advances its byte.
- grant, out, 2, one-hot owner of the serializer (00 = none).
- frame_done, out, 1, one-cycle pulse when FRAME_LEN bytes of a frame have been handed off.
- ser_data, out, 8, byte to the serializer.
- ser_valid, out, 1, one-cycle load strobe to the serializer.
- ser_busy, in, 1, serializer busy (active high).
- ser_over_run, in, 1, serializer overrun flag.
- err_overrun, out, 1, sticky overrun error.

Function
REQ-004 The state machine SHALL have the states IDLE, LOAD, HOLD and DONE.
REQ-005 In IDLE with any reqN high, the block SHALL register grant to the winner and go to LOAD on the next cycle.
REQ-006 The winner SHALL be chosen round-robin: the requester served last has the lower priority, and req0 wins the first tie after reset.
REQ-007 In LOAD with ser_busy=0, the block SHALL, in the same cycle:
- assert ser_valid=1;
- drive ser_data = data of the granted requester;
- pulse ackN for the granted requester;
- increment byte_cnt (8-bit);
- go to HOLD.
REQ-008 In LOAD with ser_busy=1, the block SHALL stay in LOAD with ser_valid=0.
REQ-009 HOLD SHALL last exactly GAP_CYCLES cycles with ser_valid=0. It then goes to DONE if byte_cnt==FRAME_LEN, otherwise to LOAD.
REQ-010 DONE SHALL pulse frame_done for one cycle, clear grant and byte_cnt, update the round-robin pointer, and return to IDLE.
REQ-011 If the granted reqN drops in LOAD or HOLD, the block SHALL abort the frame:
- go to IDLE the next cycle;
- clear grant and byte_cnt;
- not pulse frame_done;
- still advance the round-robin pointer.
REQ-012 A byte already strobed SHALL NOT be retracted.
REQ-013 A request from the non-granted requester SHALL be ignored until the current frame ends or aborts, so frames are atomic.
REQ-014 Latency: req asserted in IDLE at cycle N with ser_busy=0 throughout SHALL give grant at N+1 and the first ser_valid at N+2. Later bytes SHALL be spaced GAP_CYCLES+1 cycles apart.
REQ-015 ser_over_run=1 in any cycle SHALL set err_overrun=1, which holds until reset.
REQ-016 ser_valid and ackN SHALL never be high in two consecutive cycles.

Reset
REQ-017 With reset high at a clock edge, the block SHALL set:
- state = IDLE;
- grant = 00;
- ser_valid, ack0, ack1, frame_done, err_overrun = 0;
- ser_data = 8'hFF;
- byte_cnt = 0;
- round-robin pointer favouring req0.
REQ-018 Reset asserted mid-frame SHALL abandon the frame with no further strobes, and no frame_done pulse SHALL follow.

Configuration
REQ-019 With macro SPI_ARB_TIMEOUT_EN defined, the block SHALL provide:
- a 10-bit watchdog counting consecutive LOAD cycles with ser_busy=1;
- on reaching TIMEOUT_CYCLES, an abort exactly as in REQ-011;
- an extra output err_timeout (1 bit, sticky until reset).
REQ-020 Without SPI_ARB_TIMEOUT_EN, the block SHALL have no err_timeout port and no watchdog logic, and LOAD SHALL wait indefinitely.

Structure
REQ-021 State encodings (IDLE=0, LOAD=1, HOLD=2, DONE=3), the default FRAME_LEN and the default GAP_CYCLES SHALL live in the shared SPI constants package, shared with the serializer.
REQ-022 Round-robin selection SHALL be a sub-module, rr_arbiter2. Its inputs are req[1:0], the pointer and an enable; its output is a one-hot grant.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- req0 only, data0 = 8'hA5..8'hAC, ser_busy=0 -> 8 ser_valid strobes 3 cycles apart carrying A5..AC, 8 ack0 pulses, then one frame_done.
- req0 and req1 raised in the same cycle after reset -> grant=01 first; after frame_done, grant=10 with no IDLE gap beyond one cycle.
- ser_busy held high for 20 cycles in LOAD -> no ser_valid during those cycles; a strobe on the first cycle after busy drops.
- req1 dropped after 3 bytes -> exactly 3 ack1 pulses, no frame_done, grant=00 the next cycle, and req0 wins the next tie.
- ser_over_run pulsed for 1 cycle -> err_overrun=1 and held until reset; reset mid-frame -> all outputs at reset values on the next cycle.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, ser_busy stuck high -> abort after 16 LOAD cycles, err_timeout=1.

Source files
------------

// File: rtl/spi_tx_arbiter_pkg.sv
// Shared SPI constants: FSM state encoding and default frame geometry,
// common to the transmit arbiter and the serializer.
package spi_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } arb_state_t;

   localparam int DEF_FRAME_LEN  = 8;
   localparam int DEF_GAP_CYCLES = 2;
   localparam int WDOG_W         = 10;

endpackage

// File: rtl/spi_tx_arbiter_rr_arbiter2.sv
// Two-way round-robin selector. i_ptr = 0 favours requester 0 on a tie,
// i_ptr = 1 favours requester 1. Output is one-hot, or 00 when disabled.
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   input  logic       i_en,
   output logic [1:0] o_grant
);

   // Combinational pick: a lone requester always wins, a tie follows the pointer.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no latch is inferred.
      o_grant = 2'b00;
      if (i_en) begin
         if (i_req == 2'b11) begin
            o_grant = i_ptr ? 2'b10 : 2'b01;
         end else begin
            o_grant = i_req;
         end
      end
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Two-requester frame arbiter in front of a byte serializer. A granted
// requester owns the serializer for FRAME_LEN bytes; bytes are strobed with
// GAP_CYCLES idle cycles between them. Dropping the request aborts the frame.
// Optional feature: define SPI_ARB_TIMEOUT_EN to add a LOAD-stall watchdog
// and the sticky err_timeout output.
module spi_tx_arbiter
   import spi_tx_arbiter_pkg::*;
#(
   parameter int FRAME_LEN      = DEF_FRAME_LEN,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic [1:0] grant,
   output logic       frame_done,
   output logic [7:0] ser_data,
   output logic       ser_valid,
   input  logic       ser_busy,
   input  logic       ser_over_run,
`ifdef SPI_ARB_TIMEOUT_EN
   output logic       err_overrun,
   output logic       err_timeout
`else
   output logic       err_overrun
`endif
);

   localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);
   localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

   arb_state_t r_state;
   logic [1:0] r_grant;
   logic       r_rr_ptr;
   logic [7:0] r_byte_cnt;
   logic [7:0] r_gap_cnt;
   logic [7:0] r_ser_data;
   logic       r_ser_valid;
   logic       r_ack0;
   logic       r_ack1;
   logic       r_frame_done;
   logic       r_err_overrun;

   logic [1:0] w_arb_grant;
   logic       w_req_held;
   logic       w_abort;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
   logic [WDOG_W-1:0] r_wd_cnt;
   logic              r_err_timeout;
   logic              w_wd_expire;
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

   // A new owner is only chosen while idle, which keeps frames atomic.
   rr_arbiter2 u_rr (
      .i_req   ({req1, req0}),
      .i_ptr   (r_rr_ptr),
      .i_en    (r_state == ST_IDLE),
      .o_grant (w_arb_grant)
   );

   // Abort detection: owner dropped its request mid-frame, or the watchdog fired.
   always_comb begin
      w_req_held = |(r_grant & {req1, req0});
`ifdef SPI_ARB_TIMEOUT_EN
      w_wd_expire = (r_state == ST_LOAD) && ser_busy && (r_wd_cnt == WD_LAST);
      w_abort     = (((r_state == ST_LOAD) || (r_state == ST_HOLD)) && !w_req_held) ||
                    w_wd_expire;
`else
      w_abort     = ((r_state == ST_LOAD) || (r_state == ST_HOLD)) && !w_req_held;
`endif
   end

   // Main sequencer: grant, byte hand-off, inter-byte gap, frame completion or abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_grant       <= 2'b00;
         r_rr_ptr      <= 1'b0;
         r_byte_cnt    <= 8'd0;
         r_gap_cnt     <= 8'd0;
         r_ser_data    <= 8'hFF;
         r_ser_valid   <= 1'b0;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_err_overrun <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_ser_valid  <= 1'b0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_frame_done <= 1'b0;
         if (ser_over_run) begin
            r_err_overrun <= 1'b1;
         end
         if (w_abort) begin
            // The loser of the aborted frame still gets rotated behind the other side.
            r_grant    <= 2'b00;
            r_byte_cnt <= 8'd0;
            r_rr_ptr   <= r_grant[0];
            r_state    <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_arb_grant != 2'b00) begin
                     r_grant <= w_arb_grant;
                     r_state <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (!ser_busy) begin
                     r_ser_valid <= 1'b1;
                     r_ser_data  <= r_grant[1] ? data1 : data0;
                     r_ack0      <= r_grant[0];
                     r_ack1      <= r_grant[1];
                     r_byte_cnt  <= r_byte_cnt + 8'd1;
                     r_gap_cnt   <= 8'd0;
                     r_state     <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (r_gap_cnt == GAP_LAST) begin
                     if (r_byte_cnt == FRAME_LEN_B) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_DONE;
                     end else begin
                        r_state <= ST_LOAD;
                     end
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 8'd1;
                  end
               end
               ST_DONE: begin
                  r_grant    <= 2'b00;
                  r_byte_cnt <= 8'd0;
                  r_rr_ptr   <= r_grant[0];
                  r_state    <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   // Watchdog: counts consecutive stalled LOAD cycles and latches the timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd_cnt      <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         if ((r_state == ST_LOAD) && ser_busy && !w_abort) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
         end else begin
            r_wd_cnt <= '0;
         end
         if (w_wd_expire) begin
            r_err_timeout <= 1'b1;
         end
      end
   end

   assign err_timeout = r_err_timeout;
`endif

   assign grant       = r_grant;
   assign ack0        = r_ack0;
   assign ack1        = r_ack1;
   assign frame_done  = r_frame_done;
   assign ser_data    = r_ser_data;
   assign ser_valid   = r_ser_valid;
   assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: single frame, tie/rotation, serializer
// stall, request abort, overrun flag and mid-frame reset. With
// SPI_ARB_TIMEOUT_EN defined it also exercises the LOAD watchdog.
`timescale 1ns/1ps
module tb_spi_tx_arbiter;

   localparam int FRAME_LEN = 8;
   localparam int GAP       = 2;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TIMEOUT   = 16;
   localparam int BUSY_LEN  = 12;
`else
   localparam int TIMEOUT   = 1023;
   localparam int BUSY_LEN  = 20;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;
   logic       ser_busy = 1'b0;
   logic       ser_over_run = 1'b0;
   logic       ack0;
   logic       ack1;
   logic [1:0] grant;
   logic       frame_done;
   logic [7:0] ser_data;
   logic       ser_valid;
   logic       err_overrun;
`ifdef SPI_ARB_TIMEOUT_EN
   logic       err_timeout;
`endif

   int vectors = 0;
   int miscompares = 0;

   spi_tx_arbiter #(
      .FRAME_LEN      (FRAME_LEN),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req0         (req0),
      .req1         (req1),
      .data0        (data0),
      .data1        (data1),
      .ack0         (ack0),
      .ack1         (ack1),
      .grant        (grant),
      .frame_done   (frame_done),
      .ser_data     (ser_data),
      .ser_valid    (ser_valid),
      .ser_busy     (ser_busy),
      .ser_over_run (ser_over_run),
`ifdef SPI_ARB_TIMEOUT_EN
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout)
`else
      .err_overrun  (err_overrun)
`endif
   );

   always #5 clk = ~clk;

   // One clock; outputs are observed 1 ns after the edge. Requesters step
   // their byte on each ack, as a real source would.
   task automatic step();
      @(posedge clk);
      #1;
      if (ack0) data0 = data0 + 8'd1;
      if (ack1) data1 = data1 + 8'd1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Runs one granted frame from the cycle after grant to frame_done.
   task automatic run_frame(input logic [1:0] who, input logic [7:0] first, input string tag);
      int         n_strobe;
      int         since;
      logic       done;
      logic [7:0] exp_data;
      int         exp_since;
      n_strobe = 0;
      since    = 0;
      done     = 1'b0;
      exp_data = first;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         step();
         since++;
         vectors++;
         if ({ack1, ack0} !== (ser_valid ? who : 2'b00)) begin
            $display("FAIL %s_ack: got %b expected %b", tag, {ack1, ack0}, (ser_valid ? who : 2'b00));
            miscompares++;
         end
         if (ser_valid) begin
            exp_since = (n_strobe == 0) ? 1 : GAP + 1;
            vectors++;
            if (ser_data !== exp_data) begin
               $display("FAIL %s_data[%0d]: got %h expected %h", tag, n_strobe, ser_data, exp_data);
               miscompares++;
            end
            vectors++;
            if (since != exp_since) begin
               $display("FAIL %s_spacing[%0d]: got %0d expected %0d", tag, n_strobe, since, exp_since);
               miscompares++;
            end
            n_strobe++;
            since    = 0;
            exp_data = exp_data + 8'd1;
         end
         if (frame_done) begin
            done = 1'b1;
            vectors++;
            if (n_strobe != FRAME_LEN) begin
               $display("FAIL %s_strobe_count: got %0d expected %0d", tag, n_strobe, FRAME_LEN);
               miscompares++;
            end
            vectors++;
            if (since != GAP) begin
               $display("FAIL %s_done_latency: got %0d expected %0d", tag, since, GAP);
               miscompares++;
            end
         end
      end
      if (!done) begin
         vectors++;
         $display("FAIL %s_no_frame_done: got %0d strobes expected frame_done", tag, n_strobe);
         miscompares++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({grant, ser_valid, ack0, ack1, frame_done, err_overrun} !== 7'b0) begin
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {grant, ser_valid, ack0, ack1, frame_done, err_overrun});
         miscompares++;
      end
      vectors++;
      if (ser_data !== 8'hFF) begin
         $display("FAIL reset_ser_data: got %h expected ff", ser_data);
         miscompares++;
      end
   endtask

   task automatic test_single_frame();
      data0 = 8'hA5;
      req0  = 1'b1;
      step();
      vectors++;
      if (grant !== 2'b01) begin
         $display("FAIL single_grant: got %b expected 01", grant);
         miscompares++;
      end
      vectors++;
      if (ser_valid !== 1'b0) begin
         $display("FAIL single_early_strobe: got %b expected 0", ser_valid);
         miscompares++;
      end
      run_frame(2'b01, 8'hA5, "single");
      req0 = 1'b0;
      step();
      vectors++;
      if ({frame_done, grant} !== 3'b000) begin
         $display("FAIL single_after_done: got %b expected 000", {frame_done, grant});
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      data0 = 8'h10;
      data1 = 8'h50;
      req0  = 1'b1;
      req1  = 1'b1;
      step();
      vectors++;
      if (grant !== 2'b01) begin
         $display("FAIL tie_first_grant: got %b expected 01", grant);
         miscompares++;
      end
      run_frame(2'b01, 8'h10, "tie0");
      req0 = 1'b0;
      step();
      vectors++;
      if (grant !== 2'b00) begin
         $display("FAIL tie_idle_gap: got %b expected 00", grant);
         miscompares++;
      end
      step();
      vectors++;
      if (grant !== 2'b10) begin
         $display("FAIL tie_second_grant: got %b expected 10", grant);
         miscompares++;
      end
      run_frame(2'b10, 8'h50, "tie1");
      req1 = 1'b0;
      step();
      vectors++;
      if (grant !== 2'b00) begin
         $display("FAIL tie_release: got %b expected 00", grant);
         miscompares++;
      end
   endtask

   task automatic test_busy_stall();
      int n_valid;
      n_valid  = 0;
      ser_busy = 1'b1;
      data0    = 8'h77;
      req0     = 1'b1;
      step();
      vectors++;
      if (grant !== 2'b01) begin
         $display("FAIL busy_grant: got %b expected 01", grant);
         miscompares++;
      end
      for (int i = 0; i < BUSY_LEN; i++) begin
         step();
         if (ser_valid) n_valid++;
      end
      vectors++;
      if (n_valid != 0 || grant !== 2'b01) begin
         $display("FAIL busy_strobes: got %0d strobes grant %b expected 0 strobes grant 01", n_valid, grant);
         miscompares++;
      end
      ser_busy = 1'b0;
      step();
      vectors++;
      if ({ser_valid, ser_data} !== {1'b1, 8'h77}) begin
         $display("FAIL busy_release_strobe: got %b/%h expected 1/77", ser_valid, ser_data);
         miscompares++;
      end
      req0 = 1'b0;
      step();
      vectors++;
      if ({grant, ack0, ser_valid} !== 4'b0000) begin
         $display("FAIL busy_abort: got %b expected 0000", {grant, ack0, ser_valid});
         miscompares++;
      end
   endtask

   task automatic test_abort();
      int n_ack;
      int extra;
      n_ack = 0;
      extra = 0;
      data1 = 8'h30;
      req1  = 1'b1;
      step();
      vectors++;
      if (grant !== 2'b10) begin
         $display("FAIL abort_grant: got %b expected 10", grant);
         miscompares++;
      end
      for (int i = 0; i < 30 && n_ack < 3; i++) begin
         step();
         if (ack1) begin
            n_ack++;
            if (n_ack == 3) begin
               vectors++;
               if (ser_data !== 8'h32) begin
                  $display("FAIL abort_third_byte: got %h expected 32", ser_data);
                  miscompares++;
               end
            end
         end
      end
      req1 = 1'b0;
      step();
      vectors++;
      if ({grant, frame_done} !== 3'b000) begin
         $display("FAIL abort_release: got %b expected 000", {grant, frame_done});
         miscompares++;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         if (ack1 || ack0 || ser_valid || frame_done) extra++;
      end
      vectors++;
      if (n_ack != 3 || extra != 0) begin
         $display("FAIL abort_counts: got %0d acks %0d extra expected 3 acks 0 extra", n_ack, extra);
         miscompares++;
      end
      req0 = 1'b1;
      req1 = 1'b1;
      step();
      vectors++;
      if (grant !== 2'b01) begin
         $display("FAIL abort_next_tie: got %b expected 01", grant);
         miscompares++;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      step();
      vectors++;
      if ({grant, ser_valid} !== 3'b000) begin
         $display("FAIL abort_in_load: got %b expected 000", {grant, ser_valid});
         miscompares++;
      end
   endtask

   task automatic test_overrun_reset();
      int extra;
      extra = 0;
      ser_over_run = 1'b1;
      step();
      ser_over_run = 1'b0;
      vectors++;
      if (err_overrun !== 1'b1) begin
         $display("FAIL overrun_set: got %b expected 1", err_overrun);
         miscompares++;
      end
      for (int i = 0; i < 5; i++) step();
      vectors++;
      if (err_overrun !== 1'b1) begin
         $display("FAIL overrun_sticky: got %b expected 1", err_overrun);
         miscompares++;
      end
      data0 = 8'hC0;
      req0  = 1'b1;
      step();
      step();
      vectors++;
      if ({ser_valid, ser_data} !== {1'b1, 8'hC0}) begin
         $display("FAIL midframe_strobe: got %b/%h expected 1/c0", ser_valid, ser_data);
         miscompares++;
      end
      reset = 1'b1;
      req0  = 1'b0;
      step();
      vectors++;
      if ({grant, ser_valid, ack0, ack1, frame_done, err_overrun, ser_data} !== {7'b0, 8'hFF}) begin
         $display("FAIL midframe_reset: got %b/%h expected 0000000/ff",
                  {grant, ser_valid, ack0, ack1, frame_done, err_overrun}, ser_data);
         miscompares++;
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ser_valid || frame_done || ack0) extra++;
      end
      vectors++;
      if (extra != 0) begin
         $display("FAIL reset_quiet: got %0d events expected 0", extra);
         miscompares++;
      end
   endtask

`ifdef SPI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      ser_busy = 1'b1;
      req0     = 1'b1;
      step();
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      vectors++;
      if ({grant, err_timeout} !== 3'b010) begin
         $display("FAIL timeout_early: got %b expected 010", {grant, err_timeout});
         miscompares++;
      end
      step();
      vectors++;
      if ({grant, err_timeout, frame_done} !== 4'b0010) begin
         $display("FAIL timeout_abort: got %b expected 0010", {grant, err_timeout, frame_done});
         miscompares++;
      end
      req0     = 1'b0;
      ser_busy = 1'b0;
      step();
      vectors++;
      if (err_timeout !== 1'b1) begin
         $display("FAIL timeout_sticky: got %b expected 1", err_timeout);
         miscompares++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_busy_stall();
      test_abort();
      test_overrun_reset();
`ifdef SPI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_time_limit: got no completion expected finish within 100 us");
      $fatal(1);
   end

endmodule
